// File: rtl/rcu_pll_seq_if.sv
// Config request handshake between the RCU register file and the PLL sequencer.
interface rcu_pll_seq_if;
    localparam int unsigned REFDIV_W  = 6;
    localparam int unsigned FBDIV_W   = 12;
    localparam int unsigned POSTDIV_W = 3;

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [REFDIV_W-1:0]  cfg_refdiv;
    logic [FBDIV_W-1:0]   cfg_fbdiv;
    logic [POSTDIV_W-1:0] cfg_postdiv1;
    logic [POSTDIV_W-1:0] cfg_postdiv2;

    modport master (
        output cfg_valid, cfg_refdiv, cfg_fbdiv, cfg_postdiv1, cfg_postdiv2,
        input  cfg_ready
    );
    modport slave (
        input  cfg_valid, cfg_refdiv, cfg_fbdiv, cfg_postdiv1, cfg_postdiv2,
        output cfg_ready
    );
endinterface

// File: rtl/rcu_pll_seq.sv
// RCU PLL reprogramming sequencer: bypass -> power-down/reprogram -> lock wait -> switch back.
// Optional lock-loss monitor in IDLE enabled by macro RCU_PLL_SEQ_LOCK_MON_EN.
module rcu_pll_seq #(
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned LOCK_CONSEC = 4,
    parameter int unsigned TMO_WIDTH   = 16,
    parameter logic [5:0]  RST_REFDIV  = 6'd1,
    parameter logic [11:0] RST_FBDIV   = 12'd32,
    parameter logic [2:0]  RST_POSTDIV = 3'd1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    rcu_pll_seq_if.slave         cfg,
    input  logic [TMO_WIDTH-1:0] timeout_i,
    input  logic                 pll_lock_i,
    output logic                 pll_pd_o,
    output logic [5:0]           pll_refdiv_o,
    output logic [11:0]          pll_fbdiv_o,
    output logic [2:0]           pll_postdiv1_o,
    output logic [2:0]           pll_postdiv2_o,
    output logic                 clk_sel_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);
    localparam int unsigned SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned RUN_W    = $clog2(LOCK_CONSEC + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_BYPASS, ST_PD, ST_LOCK, ST_SWITCH, ST_FAIL
    } state_e;

    state_e                 state_q, state_d;
    logic [SETTLE_W-1:0]    settle_q, settle_d;
    logic [TMO_WIDTH-1:0]   tmo_q, tmo_d;
    logic [5:0]             cap_ref_q, cap_ref_d, ref_q, ref_d;
    logic [11:0]            cap_fb_q, cap_fb_d, fb_q, fb_d;
    logic [2:0]             cap_p1_q, cap_p1_d, p1_q, p1_d;
    logic [2:0]             cap_p2_q, cap_p2_d, p2_q, p2_d;
    logic                   pd_q, pd_d, sel_q, sel_d, busy_q, busy_d;
    logic                   done_q, done_d, err_q, err_d, ready_q, ready_d;
    logic                   sync1_q, sync1_d, lock_s_q, lock_s_d;
    logic [RUN_W-1:0]       run_cnt_q, run_cnt_d;
    logic                   lock_ok, accept, cfg_bad, settle_end;
`ifdef RCU_PLL_SEQ_LOCK_MON_EN
    logic                   lock_prev_q, lock_prev_d;
`endif

    assign lock_ok    = (run_cnt_q == RUN_W'(LOCK_CONSEC));
    assign accept     = cfg.cfg_valid && ready_q;
    assign cfg_bad    = (cfg.cfg_refdiv == '0) || (cfg.cfg_fbdiv == '0) ||
                        (cfg.cfg_postdiv1 == '0) || (cfg.cfg_postdiv2 == '0);
    assign settle_end = (settle_q == SETTLE_W'(SETTLE_CYC - 1));

    // Lock synchronizer and saturating run-length counter of synced lock.
    always_comb begin
        sync1_d   = pll_lock_i;
        lock_s_d  = sync1_q;
        run_cnt_d = run_cnt_q;
        if (!lock_s_q) begin
            run_cnt_d = '0;
        end else if (!lock_ok) begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
        end
`ifdef RCU_PLL_SEQ_LOCK_MON_EN
        lock_prev_d = lock_s_q;
`endif
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        tmo_d     = tmo_q;
        cap_ref_d = cap_ref_q;
        cap_fb_d  = cap_fb_q;
        cap_p1_d  = cap_p1_q;
        cap_p2_d  = cap_p2_q;
        ref_d     = ref_q;
        fb_d      = fb_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        pd_d      = pd_q;
        sel_d     = sel_q;
        done_d    = 1'b0;
        err_d     = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    err_d     = 1'b0;
                    cap_ref_d = cfg.cfg_refdiv;
                    cap_fb_d  = cfg.cfg_fbdiv;
                    cap_p1_d  = cfg.cfg_postdiv1;
                    cap_p2_d  = cfg.cfg_postdiv2;
                    if (cfg_bad) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d  = ST_BYPASS;
                        settle_d = '0;
                        sel_d    = 1'b0;
                    end
                end
`ifdef RCU_PLL_SEQ_LOCK_MON_EN
                else if (sel_q && !lock_s_q && !lock_prev_q) begin
                    sel_d  = 1'b0;
                    pd_d   = 1'b1;
                    err_d  = 1'b1;
                    done_d = 1'b1;
                end
`endif
            end
            ST_BYPASS: begin
                if (settle_end) begin
                    // Dividers load together with power-down, never while running.
                    state_d  = ST_PD;
                    settle_d = '0;
                    pd_d     = 1'b1;
                    ref_d    = cap_ref_q;
                    fb_d     = cap_fb_q;
                    p1_d     = cap_p1_q;
                    p2_d     = cap_p2_q;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            ST_PD: begin
                if (settle_end) begin
                    state_d  = ST_LOCK;
                    settle_d = '0;
                    pd_d     = 1'b0;
                    tmo_d    = '0;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            ST_LOCK: begin
                tmo_d = tmo_q + TMO_WIDTH'(1);
                if (lock_ok) begin
                    state_d  = ST_SWITCH;
                    settle_d = '0;
                    sel_d    = 1'b1;
                end else if ((timeout_i != '0) && (tmo_q == (timeout_i - TMO_WIDTH'(1)))) begin
                    state_d = ST_FAIL;
                    pd_d    = 1'b1;
                end
            end
            ST_SWITCH: begin
                if (settle_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            ST_FAIL: begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // Lock synchronizer registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            run_cnt_q   <= '0;
`ifdef RCU_PLL_SEQ_LOCK_MON_EN
            lock_prev_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            lock_s_q    <= lock_s_d;
            run_cnt_q   <= run_cnt_d;
`ifdef RCU_PLL_SEQ_LOCK_MON_EN
            lock_prev_q <= lock_prev_d;
`endif
        end
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            tmo_q     <= '0;
            cap_ref_q <= RST_REFDIV;
            cap_fb_q  <= RST_FBDIV;
            cap_p1_q  <= RST_POSTDIV;
            cap_p2_q  <= RST_POSTDIV;
            ref_q     <= RST_REFDIV;
            fb_q      <= RST_FBDIV;
            p1_q      <= RST_POSTDIV;
            p2_q      <= RST_POSTDIV;
            pd_q      <= 1'b1;
            sel_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            tmo_q     <= tmo_d;
            cap_ref_q <= cap_ref_d;
            cap_fb_q  <= cap_fb_d;
            cap_p1_q  <= cap_p1_d;
            cap_p2_q  <= cap_p2_d;
            ref_q     <= ref_d;
            fb_q      <= fb_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            pd_q      <= pd_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
        end
    end

    assign cfg.cfg_ready    = ready_q;
    assign pll_pd_o         = pd_q;
    assign pll_refdiv_o     = ref_q;
    assign pll_fbdiv_o      = fb_q;
    assign pll_postdiv1_o   = p1_q;
    assign pll_postdiv2_o   = p2_q;
    assign clk_sel_o        = sel_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
endmodule

// File: tb/tb_rcu_pll_seq.sv
// Randomized self-checking bench for rcu_pll_seq with a transaction-level latency model.
module tb_rcu_pll_seq;
    localparam int S      = 8;
    localparam int CONSEC = 4;
    localparam int TW     = 16;
    localparam logic [23:0] RST_DIV = {6'd1, 12'd32, 3'd1, 3'd1};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [TW-1:0] timeout;
    logic          pll_lock;
    logic          pll_pd, clk_sel, busy, done, err;
    logic [5:0]    refdiv;
    logic [11:0]   fbdiv;
    logic [2:0]    postdiv1, postdiv2;

    rcu_pll_seq_if cfg_if ();

    rcu_pll_seq dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .cfg            (cfg_if),
        .timeout_i      (timeout),
        .pll_lock_i     (pll_lock),
        .pll_pd_o       (pll_pd),
        .pll_refdiv_o   (refdiv),
        .pll_fbdiv_o    (fbdiv),
        .pll_postdiv1_o (postdiv1),
        .pll_postdiv2_o (postdiv2),
        .clk_sel_o      (clk_sel),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [23:0] exp_div;
    logic [23:0] prev_div;
    logic        exp_sel, exp_pd, exp_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] div_now();
        return {refdiv, fbdiv, postdiv1, postdiv2};
    endfunction

    // One clock, sample after the edge; dividers may only move while powered down.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (div_now() !== prev_div) check_eq("div_change_pd", 32'(pll_pd), 32'd1);
        prev_div = div_now();
    endtask

    task automatic check_idle_state(input string tag);
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        check_eq({tag, "_sel"}, 32'(clk_sel), 32'(exp_sel));
        check_eq({tag, "_pd"}, 32'(pll_pd), 32'(exp_pd));
        check_eq({tag, "_div"}, 32'(div_now()), 32'(exp_div));
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_ready"}, 32'(cfg_if.cfg_ready), 32'd1);
    endtask

    // d: LOCK cycles before lock_i rises (-1 = never); glitch: 3-high/3-low lock pulses.
    task automatic do_req(input logic [5:0] rd, input logic [11:0] fb, input logic [2:0] p1,
                          input logic [2:0] p2, input int tmo, input int d,
                          input bit glitch, input bit intrude);
        int          t0, got, exp_lat, rel;
        bit          ok;
        logic [23:0] req;
        req = {rd, fb, p1, p2};
        check_eq("ready_pre", 32'(cfg_if.cfg_ready), 32'd1);
        timeout = TW'(tmo);
        cfg_if.cfg_refdiv   = rd;
        cfg_if.cfg_fbdiv    = fb;
        cfg_if.cfg_postdiv1 = p1;
        cfg_if.cfg_postdiv2 = p2;
        cfg_if.cfg_valid    = 1'b1;
        tick();
        cfg_if.cfg_valid = 1'b0;
        t0 = cyc;
        if (rd == 0 || fb == 0 || p1 == 0 || p2 == 0) begin
            exp_err = 1'b1;
            check_eq("bad_done", 32'(done), 32'd1);
            check_idle_state("bad");
            tick();
            check_eq("bad_done_pulse", 32'(done), 32'd0);
            check_eq("bad_busy2", 32'(busy), 32'd0);
            return;
        end
        pll_lock = 1'b0;
        ok = (tmo == 0) || (!glitch && d >= 0 && d + CONSEC + 3 <= tmo);
        exp_lat = ok ? 3 * S + d + CONSEC + 3 : 2 * S + tmo + 1;
        got = -1;
        for (int i = 0; i < exp_lat + 20; i++) begin
            tick();
            rel = cyc - t0 - 2 * S;
            if (glitch) pll_lock = (rel >= 0) && ((rel % 6) < 3);
            else        pll_lock = (d >= 0) && (rel >= d);
            if (cyc == t0 + 1) check_eq("busy_accept", 32'(busy), 32'd1);
            if (cyc == t0 + S + 1) check_eq("pd_in_pd", 32'(pll_pd), 32'd1);
            if (cyc == t0 + S + 1) check_eq("sel_in_pd", 32'(clk_sel), 32'd0);
            if (cyc == t0 + 2 * S + 1) check_eq("pd_in_lock", 32'(pll_pd), 32'd0);
            if (intrude && cyc == t0 + 3) begin
                cfg_if.cfg_refdiv = 6'($urandom_range(1, 63));
                cfg_if.cfg_fbdiv  = 12'($urandom_range(1, 4095));
                cfg_if.cfg_valid  = 1'b1;
            end
            if (intrude && (cyc == t0 + 3 || cyc == t0 + 4))
                check_eq("ready_busy", 32'(cfg_if.cfg_ready), 32'd0);
            if (intrude && cyc == t0 + 5) cfg_if.cfg_valid = 1'b0;
            if (done) begin
                got = cyc - t0;
                break;
            end
        end
        check_eq("done_latency", 32'(got), 32'(exp_lat));
        exp_div = req;
        exp_sel = ok;
        exp_pd  = !ok;
        exp_err = !ok;
        check_idle_state("end");
        if (!ok) pll_lock = 1'b0;
        tick();
        check_eq("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        logic [5:0]  rd;
        logic [11:0] fb;
        logic [2:0]  p1, p2;
        int          tmo, d, t0, got;
        bit          gl;

        rst_n = 1'b0;
        pll_lock = 1'b0;
        timeout = '0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_refdiv = '0;
        cfg_if.cfg_fbdiv = '0;
        cfg_if.cfg_postdiv1 = '0;
        cfg_if.cfg_postdiv2 = '0;
        exp_div = RST_DIV;
        exp_sel = 1'b0;
        exp_pd  = 1'b1;
        exp_err = 1'b0;
        repeat (3) tick();
        check_eq("rst_done", 32'(done), 32'd0);
        check_idle_state("rst");
        rst_n = 1'b1;
        tick();
        check_idle_state("idle");

        // Reference example: lock 20 cycles into LOCK.
        do_req(6'd1, 12'd100, 3'd2, 3'd1, 1000, 20, 1'b0, 1'b0);

        // Lock loss after a completed sequence.
        repeat (3) tick();
        pll_lock = 1'b0;
`ifdef RCU_PLL_SEQ_LOCK_MON_EN
        got = -1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!clk_sel) begin
                got = i + 1;
                break;
            end
        end
        check_eq("mon_within4", 32'((got >= 1) && (got <= 4)), 32'd1);
        check_eq("mon_done", 32'(done), 32'd1);
        exp_sel = 1'b0;
        exp_pd  = 1'b1;
        exp_err = 1'b1;
        check_idle_state("mon");
`else
        repeat (10) tick();
        check_idle_state("nomon");
`endif

        // Timeout with lock never rising, glitchy lock, bad config, intruding request.
        do_req(6'd2, 12'd64, 3'd1, 3'd1, 50, -1, 1'b0, 1'b0);
        do_req(6'd3, 12'd80, 3'd2, 3'd2, 60, 0, 1'b1, 1'b0);
        do_req(6'd3, 12'd0, 3'd1, 3'd1, 100, 5, 1'b0, 1'b0);
        do_req(6'd2, 12'd50, 3'd1, 3'd1, 0, 10, 1'b0, 1'b1);
        // Lock qualifies exactly on the last allowed cycle, then one cycle too late.
        do_req(6'd5, 12'd200, 3'd3, 3'd4, 10 + CONSEC + 3, 10, 1'b0, 1'b0);
        do_req(6'd4, 12'd150, 3'd1, 3'd2, 10 + CONSEC + 2, 10, 1'b0, 1'b0);

        for (int n = 0; n < 12; n++) begin
            rd  = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            fb  = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
            p1  = 3'($urandom_range(1, 7));
            p2  = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            tmo = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(15, 90));
            d   = int'($urandom_range(0, 70));
            gl  = (tmo != 0) && ($urandom_range(0, 5) == 0);
            do_req(rd, fb, p1, p2, tmo, d, gl, ($urandom_range(0, 3) == 0));
        end

        // Reset while waiting for lock.
        timeout = '0;
        cfg_if.cfg_refdiv = 6'd7;
        cfg_if.cfg_fbdiv = 12'd99;
        cfg_if.cfg_postdiv1 = 3'd2;
        cfg_if.cfg_postdiv2 = 3'd3;
        cfg_if.cfg_valid = 1'b1;
        tick();
        cfg_if.cfg_valid = 1'b0;
        pll_lock = 1'b0;
        t0 = cyc;
        while (cyc < t0 + 2 * S + 5) tick();
        check_eq("lock_pd", 32'(pll_pd), 32'd0);
        rst_n = 1'b0;
        tick();
        exp_div = RST_DIV;
        exp_sel = 1'b0;
        exp_pd  = 1'b1;
        exp_err = 1'b0;
        check_idle_state("rst_lock");
        rst_n = 1'b1;
        tick();
        do_req(6'd1, 12'd40, 3'd1, 3'd1, 200, 3, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
